// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StFetch = 2'd1,
    StStall = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter, cleared only by reset.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'h0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch PC sequencer: stall, redirect, halt/resume and ROM handshake.
// Optional completed-fetch counter built only when FETCH_SEQ_PERF_CNT_EN is defined.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         CODE_W   = 6,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [CODE_W-1:0] pc_code,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_d, fetch_pc_d, redirect_target;
  logic              fetch_valid_d;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Target is word aligned, so the low bits are intentionally dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReset;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      fetch_pc    <= fetch_pc_d;
      fetch_valid <= fetch_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    fetch_pc_d    = fetch_pc;
    fetch_valid_d = 1'b0;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        // A redirect squashes any fetch the ROM completes in the same cycle.
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (halt_req) begin
          state_d = StHalt;
        end else if (stall) begin
          state_d = StStall;
        end else if (imem_ready) begin
          fetch_pc_d    = pc;
          pc_d          = pc + ADDR_W'(PC_STEP);
          fetch_valid_d = 1'b1;
        end
      end
      StStall: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (halt_req) begin
          state_d = StHalt;
        end else if (!stall) begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (resume && !halt_req) begin
          state_d = StFetch;
        end
      end
      default: state_d = StReset;
    endcase
  end

  assign imem_req = (state_q == StFetch);
  assign halted   = (state_q == StHalt);
  assign pc_code  = pc[CODE_W+1:2];

`ifdef FETCH_SEQ_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_valid_d),
    .count (fetch_count)
  );
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised scoreboard bench for fetch_sequencer against a behavioural PC model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, halt_req, resume, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, fetch_valid, halted;
  logic [31:0] pc, fetch_pc, fetch_count;
  logic [5:0]  pc_code;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .pc             (pc),
    .pc_code        (pc_code),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  // Model: what the sequencer is doing, independent of any encoding.
  localparam int MODE_BOOT = 0, MODE_RUN = 1, MODE_WAIT = 2, MODE_PARK = 3;
  int          m_mode;
  logic [31:0] m_pc;
  int unsigned m_fetches;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_count();
`ifdef FETCH_SEQ_PERF_CNT_EN
    return m_fetches;
`else
    return 32'h0;
`endif
  endfunction

  // Monitor: every fetch_valid pulse must match the oldest expected fetch.
  always @(negedge clk) begin
    if (!rst && fetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL fetch_pc: got unexpected fetch %h expected none", fetch_pc);
      end else begin
        check("fetch_pc", fetch_pc, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    m_mode    = MODE_BOOT;
    m_pc      = 32'h0;
    m_fetches = 0;
    exp_q.delete();
  endtask

  // Called at a negedge: check state, drive inputs, advance model, wait next negedge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit hr, input bit rs, input bit ir);
    check("pc", pc, m_pc);
    check("pc_code", {26'h0, pc_code}, {26'h0, m_pc[7:2]});
    check("imem_req", {31'h0, imem_req}, {31'h0, m_mode == MODE_RUN});
    check("halted", {31'h0, halted}, {31'h0, m_mode == MODE_PARK});
    check("fetch_count", fetch_count, exp_count());
    stall = st; redirect_valid = rd; redirect_pc = rpc;
    halt_req = hr; resume = rs; imem_ready = ir;
    case (m_mode)
      MODE_BOOT: m_mode = MODE_RUN;
      MODE_RUN: begin
        if (rd) m_pc = rpc & 32'hFFFF_FFFC;
        else if (hr) m_mode = MODE_PARK;
        else if (st) m_mode = MODE_WAIT;
        else if (ir) begin
          exp_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          m_fetches++;
        end
      end
      MODE_WAIT: begin
        if (rd) m_pc = rpc & 32'hFFFF_FFFC;
        if (hr) m_mode = MODE_PARK;
        else if (!st) m_mode = MODE_RUN;
      end
      default: begin
        if (rd) m_pc = rpc & 32'hFFFF_FFFC;
        if (rs && !hr) m_mode = MODE_RUN;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_fetch_pc"}, fetch_pc, 32'h0);
    check({tag, "_fetch_valid"}, {31'h0, fetch_valid}, 32'h0);
    check({tag, "_halted"}, {31'h0, halted}, 32'h0);
    check({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_fetch_count"}, fetch_count, 32'h0);
  endtask

  initial begin
    bit st, rd, hr, rs, ir;
    logic [31:0] rpc;
    rst = 1'b1;
    stall = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0; resume = 0; imem_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Free run, then redirect with a same-cycle ready at pc 0x10.
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h43, 0, 0, 1);
    check("redirect_pc_code", {26'h0, pc_code}, 32'd16);
    step(0, 0, 0, 0, 0, 1);
    // Stall at 0x20 with ready held high.
    step(0, 1, 32'h20, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Halt at 0x8, resume blocked by halt_req, then released.
    step(0, 1, 32'h8, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    // Wrap past the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_pc", pc, 32'h0);
    step(0, 0, 0, 0, 0, 1);

    // Asynchronous reset between edges while fetching.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 500; i++) begin
      st = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 7) == 0);
      hr = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 3) == 0);
      ir = ($urandom_range(0, 1) == 1);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                         : $urandom_range(0, 255);
      if (rd) begin
        hr = 0;
        rs = 0;
      end
      step(st, rd, rpc, hr, rs, ir);
    end
    step(0, 0, 0, 0, 0, 0);
    #1 check("fetch_queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the instruction-fetch PC for the multi-cycle CPU.
- Owns the PC register and drives the instruction-ROM request handshake.
- Applies stall, branch/jump redirect and halt/resume, then hands fetched PCs to decode.
- Produces the word-address ROM index pc_code.
- Sits between the control unit (stall/redirect/halt) and the instruction ROM.

Parameters:
ADDR_W, 32, PC width in bits
CODE_W, 6, ROM word-index width; pc_code = pc[CODE_W+1:2]
RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold fetch, no PC advance
redirect_valid  input  1  load redirect_pc (branch/jump taken)
redirect_pc  input  ADDR_W  redirect target; low 2 bits ignored (forced 0)
halt_req  input  1  enter HALT
resume  input  1  leave HALT
imem_ready  input  1  ROM accepts/returns current request this cycle
imem_req  output  1  fetch request to ROM; high only in FETCH
pc  output  ADDR_W  current PC (registered)
pc_code  output  CODE_W  ROM index, combinational slice pc[CODE_W+1:2]
fetch_valid  output  1  registered one-cycle pulse: fetch_pc holds a completed fetch
fetch_pc  output  ADDR_W  PC of completed fetch (registered)
halted  output  1  high while in HALT
fetch_count  output  32  completed-fetch counter (see Optional Feature)

Behaviour:
Reset (async, rst=1) sets:
- state=RESET, pc=RESET_PC, fetch_pc=0, fetch_valid=0, halted=0, fetch_count=0.

States (2-bit): RESET=0, FETCH=1, STALL=2, HALT=3.
- imem_req = (state==FETCH), Moore output.
- fetch_valid defaults to 0 every cycle; it is set only as described under FETCH.

RESET:
- Goes to FETCH on the next edge unconditionally; all inputs ignored.

FETCH, evaluated each edge in priority order:
1. redirect_valid: pc <= {redirect_pc[ADDR_W-1:2],2'b00}; fetch_valid <= 0, so any same-cycle imem_ready fetch is discarded; stay in FETCH.
2. halt_req: go to HALT, halted <= 1, pc unchanged, no fetch completes.
3. stall: go to STALL, pc unchanged, imem_ready ignored.
4. imem_ready: fetch_pc <= pc; pc <= pc+4; fetch_valid <= 1; stay in FETCH. Latency is 1 cycle from the ready edge to the fetch_valid pulse.
5. Otherwise: hold; imem_req stays high.

STALL:
- imem_req=0.
- redirect_valid loads pc (rule 1) and the state remains STALL while stall=1.
- halt_req goes to HALT.
- stall=0 goes to FETCH.

HALT:
- imem_req=0, halted=1.
- redirect_valid loads pc but the state stays HALT.
- resume=1 with halt_req=0 goes to FETCH and clears halted on the same edge.
- resume=1 together with halt_req=1 stays in HALT.

Arithmetic:
- pc+4 wraps modulo 2^ADDR_W.
- pc_code wraps naturally: pc 0xFC -> 0x100 gives pc_code 63 -> 0.

Reset mid-operation:
- Takes effect immediately, without waiting for an edge.
- Any pending fetch is dropped and fetch_valid falls to 0 at once.

Optional Feature:
Macro FETCH_SEQ_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every edge where fetch_valid is set to 1. It saturates at 32'hFFFF_FFFF, never wraps, and is cleared only by rst.
- Undefined: fetch_count is tied to 32'h0 and no counter logic is built.

Decomposition:
Package fetch_seq_pkg holds:
- state encodings (RESET/FETCH/STALL/HALT)
- PC_STEP=4
- default RESET_PC

Sub-module fetch_perf_cnt, a saturating 32-bit counter with inc input, is instantiated only under FETCH_SEQ_PERF_CNT_EN. The FSM and PC register stay in fetch_sequencer.

Test Plan:
- Reset then free-run, imem_ready=1: pc 0,4,8,C; fetch_valid pulses every cycle after FETCH entry with fetch_pc 0,4,8; pc_code 0,1,2,3.
- In FETCH at pc=0x10, assert imem_ready=1 and redirect_valid=1 with redirect_pc=0x43 -> pc=0x40, fetch_valid=0 next cycle, pc_code=16; the next ready fetches 0x40.
- stall=1 for 3 cycles at pc=0x20 with imem_ready=1 -> imem_req=0, pc stays 0x20, no fetch_valid; stall=0 -> FETCH, next fetch_pc=0x20.
- halt_req at pc=0x8 -> halted=1, imem_req=0. resume asserted with halt_req still high -> stays in HALT. resume with halt_req=0 -> FETCH, halted=0, fetch resumes at 0x8.
- Wrap: redirect to 0xFFFF_FFFC, then ready -> fetch_pc=0xFFFF_FFFC, pc=0x0, pc_code 63->0.
- rst asserted mid-FETCH, between edges -> outputs reset immediately. With the macro defined, after 5 fetches fetch_count=5, and it returns to 0 on reset.
